// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 bus responder.
//   state_t  : responder FSM states
//   cyc_t    : latched CPU cycle type
//   CNT_W    : wait-counter width
//   DI_RESET : read-data value after reset
package z80_bus_pkg;

  localparam int unsigned CNT_W    = 4;
  localparam logic [7:0]  DI_RESET = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    XWAIT,
    HOLD,
    DRAIN
  } state_t;

  typedef enum logic [2:0] {
    MEM_RD,
    MEM_WR,
    IO_RD,
    IO_WR,
    IACK
  } cyc_t;

  // Classify an accepted CPU cycle; acknowledge wins, then I/O, then memory.
  function automatic cyc_t classify(input logic iack, input logic io, input logic wr);
    if (iack) begin
      return IACK;
    end else if (io) begin
      return wr ? IO_WR : IO_RD;
    end else begin
      return wr ? MEM_WR : MEM_RD;
    end
  endfunction

  function automatic logic is_write(input cyc_t c);
    return (c == MEM_WR) || (c == IO_WR);
  endfunction

  function automatic logic is_io(input cyc_t c);
    return (c == IO_RD) || (c == IO_WR) || (c == IACK);
  endfunction

endpackage

// File: rtl/z80_bus_responder.sv
// Target-side Z80 bus agent: converts each CPU memory/I/O cycle into one
// request/acknowledge transaction on the backend port, stretches the CPU
// with WAIT until data is ready, and answers interrupt acknowledge locally.
// Ports:
//   CLK, nRESET               clock, asynchronous active-low reset
//   M1 MREQ IORQ RD WR RFSH   active-high CPU strobes
//   A, DO                     CPU address / write data
//   DI                        registered read data to the CPU
//   WAIT                      combinational wait request to the CPU
//   IRQ_VECTOR, INTACK        acknowledge vector / one-cycle acknowledge pulse
//   BE_*                      backend request port (registered outputs)
module z80_bus_responder
  import z80_bus_pkg::*;
#(
  parameter int unsigned EXTRA_WAIT = 0,
  parameter int unsigned IACK_WAIT  = 2
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        M1,
  input  logic        MREQ,
  input  logic        IORQ,
  input  logic        RD,
  input  logic        WR,
  input  logic        RFSH,
  input  logic [15:0] A,
  input  logic [7:0]  DO,
  output logic [7:0]  DI,
  output logic        WAIT,
  input  logic [7:0]  IRQ_VECTOR,
  output logic        INTACK,
  output logic        BE_REQ,
  output logic        BE_WE,
  output logic        BE_IO,
  output logic [15:0] BE_ADDR,
  output logic [7:0]  BE_WDATA,
  input  logic [7:0]  BE_RDATA,
  input  logic        BE_ACK
);

  localparam logic [CNT_W-1:0] EXTRA_CNT = CNT_W'(EXTRA_WAIT);
  localparam logic [CNT_W-1:0] IACK_CNT  = CNT_W'(IACK_WAIT);

  logic             acc_mem, acc_io, acc_iack, acc;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cyc_t             cyc_q, cyc_d;
  logic [7:0]       di_d;
  logic             intack_d;
  logic             be_req_d;
  logic [15:0]      addr_d;
  logic [7:0]       wdata_d;

  // Access decode; refresh cycles never qualify.
  assign acc_mem  = MREQ & ~RFSH & (RD | WR);
  assign acc_io   = IORQ & ~M1 & (RD | WR);
  assign acc_iack = IORQ & M1;
  assign acc      = acc_mem | acc_io | acc_iack;

  // WAIT must rise in the very cycle the access appears, so it is combinational.
  assign WAIT = ((state_q == IDLE) & acc)
              | (state_q == REQ)
              | ((state_q == XWAIT) & (cnt_q != '0));

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cyc_d    = cyc_q;
    di_d     = DI;
    intack_d = 1'b0;
    addr_d   = BE_ADDR;
    wdata_d  = BE_WDATA;

    case (state_q)
      IDLE: begin
        if (acc) begin
          addr_d  = A;
          wdata_d = DO;
          cyc_d   = classify(acc_iack, acc_io, WR);
          if (acc_iack) begin
            di_d     = IRQ_VECTOR;
            intack_d = 1'b1;
            cnt_d    = IACK_CNT;
            state_d  = XWAIT;
          end else begin
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        // An acknowledge in the same cycle as a CPU abort still completes normally.
        if (BE_ACK) begin
          if (!is_write(cyc_q)) begin
            di_d = BE_RDATA;
          end
          cnt_d   = EXTRA_CNT;
          state_d = XWAIT;
        end else if (!acc) begin
          state_d = DRAIN;
        end
      end
      XWAIT: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (!acc) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        // Aborted cycle: finish the backend handshake but discard the data.
        if (BE_ACK) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    be_req_d = (state_d == REQ) || (state_d == DRAIN);
  end

  // State, counter and registered outputs.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cyc_q    <= MEM_RD;
      DI       <= DI_RESET;
      INTACK   <= 1'b0;
      BE_REQ   <= 1'b0;
      BE_WE    <= 1'b0;
      BE_IO    <= 1'b0;
      BE_ADDR  <= '0;
      BE_WDATA <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cyc_q    <= cyc_d;
      DI       <= di_d;
      INTACK   <= intack_d;
      BE_REQ   <= be_req_d;
      BE_WE    <= is_write(cyc_d);
      BE_IO    <= is_io(cyc_d);
      BE_ADDR  <= addr_d;
      BE_WDATA <= wdata_d;
    end
  end

endmodule

// File: doc/z80_bus_responder.md
# z80_bus_responder

Target-side Z80 bus agent that answers memory, I/O and interrupt-acknowledge cycles issued by the TV80SI CPU wrapper. It uses the wrapper's active-high strobes. It sits between the CPU and the system's memory/peripheral fabric. It turns each CPU bus cycle into one request/acknowledge transaction on a simple backend port and holds the CPU with WAIT until data is available. Interrupt-acknowledge cycles are answered locally with a vector byte.

## Interface
Parameters:
- EXTRA_WAIT, 0: additional WAIT cycles inserted after BE_ACK, range 0–15.
- IACK_WAIT, 2: WAIT cycles inserted for interrupt acknowledge, range 0–15.

Ports:
- CLK  in  1  single clock, shared with the CPU.
- nRESET  in  1  asynchronous, active-low reset.
- M1, MREQ, IORQ, RD, WR, RFSH  in  1 each  active-high CPU strobes.
- A  in  16  CPU address.
- DO  in  8  CPU write data.
- DI  out  8  read data to the CPU; registered.
- WAIT  out  1  active-high wait request to the CPU.
- IRQ_VECTOR  in  8  byte returned during interrupt acknowledge.
- INTACK  out  1  one-cycle pulse per acknowledge.
- BE_REQ  out  1  backend request.
- BE_WE  out  1  1 = write.
- BE_IO  out  1  1 = I/O space.
- BE_ADDR  out  16  latched address.
- BE_WDATA  out  8  latched write data.
- BE_RDATA  in  8  backend read data.
- BE_ACK  in  1  backend completion; valid only while BE_REQ=1.

## Operation
Access condition (combinational), ACC:
- mem = MREQ & !RFSH & (RD|WR)
- io = IORQ & !M1 & (RD|WR)
- iack = IORQ & M1
- Refresh cycles are ignored.

FSM states: IDLE, REQ, XWAIT, HOLD, DRAIN.
- IDLE
  - On ACC, latch A, DO, and the type flags (WR, IORQ).
  - mem/io: go to REQ.
  - iack: DI<=IRQ_VECTOR, INTACK pulse, counter<=IACK_WAIT, go to XWAIT.
- REQ
  - BE_REQ=1, with fields stable until BE_ACK.
  - On BE_ACK: for a read, DI<=BE_RDATA; for a write, DI is unchanged. Counter<=EXTRA_WAIT, go to XWAIT.
  - If ACC drops before BE_ACK (CPU aborted), go to DRAIN.
- XWAIT: decrement the counter; at 0, go to HOLD.
- HOLD: DI is held; when ACC falls, go to IDLE.
- DRAIN: BE_REQ stays 1 until BE_ACK. Then go to IDLE; DI is not updated.

WAIT output:
- WAIT = (IDLE & ACC) | REQ | (XWAIT & counter≠0).
- WAIT is 0 in HOLD and in DRAIN.

Other rules:
- BE_ACK is ignored outside REQ and DRAIN.
- Reset values: state IDLE, DI=8'hFF, WAIT=0, BE_REQ=0, BE_WE=0, BE_IO=0, BE_ADDR=0, BE_WDATA=0, INTACK=0, counter=0.
- Reset asserted mid-transaction drops BE_REQ immediately. The backend must tolerate this.
- A new ACC seen in HOLD without an intervening deassert is treated as the same cycle.

## Timing
- Cycle k: ACC first true. WAIT is asserted combinationally in the same cycle.
- Cycle k+1: BE_REQ=1.
- BE_ACK in cycle j: DI is valid from j+1.
- WAIT deasserts at cycle j+1+EXTRA_WAIT.
- With BE_ACK tied high, minimum latency from ACC to WAIT low is 2+EXTRA_WAIT cycles.
- Interrupt acknowledge: INTACK is high in cycle k+1, and WAIT low from k+1+IACK_WAIT.
- Return to IDLE takes 1 cycle after ACC falls. Back-to-back cycles therefore need one idle cycle, which the CPU's T-state structure guarantees.

## Structure
- Package z80_bus_pkg:
  - FSM state enum.
  - Cycle-type encoding (MEM_RD, MEM_WR, IO_RD, IO_WR, IACK).
  - DI reset constant 8'hFF.
  - 4-bit wait-counter width.
- No sub-module. FSM, latches and counter live in one module.

## Test plan
- Memory read at A=16'h1234, backend acks 3 cycles after BE_REQ with 8'hA5 -> BE_WE=0, BE_IO=0, BE_ADDR=16'h1234; DI=8'hA5 and WAIT falls in the cycle after ACK; BE_REQ high exactly 4 cycles.
- I/O write to port 8'h7F, DO=8'h3C, EXTRA_WAIT=2 -> BE_IO=1, BE_WE=1, BE_WDATA=8'h3C; WAIT stays high 2 cycles past ACK; DI unchanged from 8'hFF.
- Interrupt acknowledge with IRQ_VECTOR=8'hFF, IACK_WAIT=2 -> one INTACK pulse, no BE_REQ, DI=8'hFF, WAIT low 3 cycles after ACC.
- Refresh cycle (MREQ&RFSH) -> no BE_REQ, WAIT stays 0, state remains IDLE.
- CPU drops strobes during REQ, ACK arrives 5 cycles later -> BE_REQ held until ACK, WAIT=0 during DRAIN, DI not updated, next cycle serviced normally.
- nRESET pulsed low while in REQ -> all outputs return to reset values asynchronously; the next read completes correctly.
